wb_regfile: RTL
===============

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter XLEN, default 32, data width of registers, results and counter.
REQ-002 Parameter NREG, default 32, number of architectural registers; addresses are 5 bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 RegWriteW  input  1  register write enable from the MEM/WB control register.
REQ-006 ResultSrcW  input  2  result select from the MEM/WB control register.
REQ-007 ValidW  input  1  an instruction retires in WB this cycle.
REQ-008 RdW  input  5  destination register address.
REQ-009 ALUResultW, ReadDataW, PCPlus4W, ImmExtW  input  XLEN each  write-back candidates.
REQ-010 Rs1D, Rs2D  input  5 each  decode-stage read addresses.
REQ-011 RD1D, RD2D  output  XLEN each  decode-stage read data.
REQ-012 ResultW  output  XLEN  selected write-back value, also used by the hazard/forwarding path.
REQ-013 RetireCount  output  XLEN  count of retired instructions.

Function
REQ-014 ResultW is combinational: ResultSrcW 00 -> ALUResultW, 01 -> ReadDataW, 10 -> PCPlus4W, 11 -> ImmExtW.
REQ-015 On a rising clk edge with RegWriteW=1 and RdW!=0, register[RdW] takes ResultW; write latency is one edge.
REQ-016 RdW=0 writes are discarded; register 0 reads as 0 at all times.
REQ-017 RD1D/RD2D are combinational reads of register[Rs1D]/register[Rs2D].
REQ-018 Write-through bypass: when RegWriteW=1, RdW!=0 and RdW equals Rs1D (resp. Rs2D), RD1D (resp. RD2D) shows ResultW in the same cycle.
REQ-019 Both read ports may bypass simultaneously when Rs1D=Rs2D=RdW.
REQ-020 Rs1D=0 or Rs2D=0 returns 0 even when RdW=0 and RegWriteW=1.
REQ-021 RetireCount increments by 1 on each rising edge with ValidW=1, independent of RegWriteW.
REQ-022 RetireCount wraps from 2^XLEN-1 to 0 without any flag.
REQ-023 RegWriteW=1 with ValidW=0 still writes the register file; the bubble case is the upstream owner's responsibility.
REQ-024 Inputs X while RegWriteW=0 leave register contents unchanged.

Reset
REQ-025 reset_n low asynchronously clears all registers and RetireCount to 0, including when asserted mid-cycle or during a write.
REQ-026 While reset_n is low, writes and counter increments are suppressed; RD1D/RD2D read 0 except through the REQ-018 bypass, which remains combinational.
REQ-027 The first write occurs on the first rising edge after reset_n is sampled high.

Structure
REQ-028 The shared pipeline package holds XLEN, NREG, the register address width (5), and the ResultSrc encodings RES_ALU=00, RES_MEM=01, RES_PC4=10, RES_IMM=11.
REQ-029 The result mux is one sub-module, result_mux4, instantiated once; storage, bypass and counter stay in wb_regfile.
REQ-030 Storage is a flop array with no RAM inference requirement.

Verification
REQ-031 Reset: drive reset_n low mid-run after writing x5=0xDEADBEEF -> RD1D(Rs1D=5)=0 and RetireCount=0 immediately, without waiting for clk.
REQ-032 Mux and write: ResultSrcW=01, ReadDataW=0x12345678, RdW=7, RegWriteW=1, one edge -> ResultW=0x12345678 during the cycle; afterwards Rs2D=7 gives RD2D=0x12345678.
REQ-033 Bypass: x3=0x1 stored; same cycle RegWriteW=1, RdW=3, ResultSrcW=10, PCPlus4W=0x104, Rs1D=Rs2D=3 -> RD1D=RD2D=0x104 before the edge.
REQ-034 x0: RegWriteW=1, RdW=0, ALUResultW=0xFFFFFFFF, one edge -> Rs1D=0 gives RD1D=0 both before and after the edge.
REQ-035 Counter: preload via 2^32-2 ValidW pulses (or force) then 3 more pulses -> RetireCount sequence 0xFFFFFFFF, 0x0, 0x1; ValidW=0 cycles hold the value.
REQ-036 Write disable: RegWriteW=0, RdW=9, ImmExtW=0xABCD, ResultSrcW=11 -> ResultW=0xABCD and x9 unchanged after the edge.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared pipeline widths and write-back result select encodings.
package wb_regfile_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } resSrc_t;
endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: write-back and decode-read signals between the pipeline and the register file.
interface wb_regfile_if #(parameter int XLEN = wb_regfile_pkg::XLEN);
    logic                         RegWriteW;
    logic [1:0]                   ResultSrcW;
    logic                         ValidW;
    logic [wb_regfile_pkg::AW-1:0] RdW;
    logic [XLEN-1:0]              ALUResultW;
    logic [XLEN-1:0]              ReadDataW;
    logic [XLEN-1:0]              PCPlus4W;
    logic [XLEN-1:0]              ImmExtW;
    logic [wb_regfile_pkg::AW-1:0] Rs1D;
    logic [wb_regfile_pkg::AW-1:0] Rs2D;
    logic [XLEN-1:0]              RD1D;
    logic [XLEN-1:0]              RD2D;
    logic [XLEN-1:0]              ResultW;
    logic [XLEN-1:0]              RetireCount;
    modport master (
        output RegWriteW, ResultSrcW, ValidW, RdW, ALUResultW, ReadDataW, PCPlus4W, ImmExtW, Rs1D, Rs2D,
        input  RD1D, RD2D, ResultW, RetireCount
    );
    modport slave (
        input  RegWriteW, ResultSrcW, ValidW, RdW, ALUResultW, ReadDataW, PCPlus4W, ImmExtW, Rs1D, Rs2D,
        output RD1D, RD2D, ResultW, RetireCount
    );
endinterface

// File: rtl/wb_regfile_result_mux4.sv
// result_mux4: selects the write-back value from the four candidate sources.
module result_mux4 import wb_regfile_pkg::*; #(parameter int W = 32) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic [W-1:0] y
);
    always_comb begin
        y = sel == RES_ALU ? a : sel == RES_MEM ? b : sel == RES_PC4 ? c : d;
    end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: flop-array register file with write-through bypass and retire counter.
module wb_regfile #(
    parameter int XLEN = wb_regfile_pkg::XLEN,
    parameter int NREG = wb_regfile_pkg::NREG
) (
    input logic        clk,
    input logic        reset_n,
    wb_regfile_if.slave bus
);
    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] retireCount;
    logic [XLEN-1:0] result;
    logic            wrEn;
    result_mux4 #(.W(XLEN)) resultMux (
        .sel(bus.ResultSrcW),
        .a  (bus.ALUResultW),
        .b  (bus.ReadDataW),
        .c  (bus.PCPlus4W),
        .d  (bus.ImmExtW),
        .y  (result)
    );
    assign wrEn            = bus.RegWriteW && bus.RdW != '0;
    assign bus.ResultW     = result;
    assign bus.RetireCount = retireCount;
    // Bypass stays live during reset because it depends only on the current WB inputs.
    always_comb begin
        bus.RD1D = bus.Rs1D == '0 ? '0 : wrEn && bus.RdW == bus.Rs1D ? result : regs[bus.Rs1D];
        bus.RD2D = bus.Rs2D == '0 ? '0 : wrEn && bus.RdW == bus.Rs2D ? result : regs[bus.Rs2D];
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            retireCount <= '0;
        end else begin
            if (wrEn) regs[bus.RdW] <= result;
            if (bus.ValidW) retireCount <= retireCount + XLEN'(1);
        end
    end
endmodule
